// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes single-byte commands from a UART receiver.
//
// Byte protocol (only bytes strobed by rx_done are looked at):
//   CMD_RUN   -> one-cycle uart_enable pulse
//   CMD_CLEAR -> one-cycle uart_clear pulse
//   CMD_MODE  -> toggles uart_mode (MODE_TOGGLE=1) or pulses it (MODE_TOGGLE=0)
//   CMD_SET   -> opens a decimal argument of up to ARG_DIGITS digits, closed by
//                CR/LF. arg_value takes the value, saturated to ARG_W bits.
//   CR/LF in idle are ignored; anything else in idle pulses cmd_error.
//   A partial argument idle for TIMEOUT cycles is aborted with cmd_error.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx_data[7:0]    received byte, valid with rx_done
//   rx_done         one-cycle byte strobe
//   uart_enable     pulse on CMD_RUN
//   uart_clear      pulse on CMD_CLEAR
//   uart_mode       level or pulse on CMD_MODE
//   arg_value       last accepted argument, held between commands
//   arg_valid       pulse when arg_value updates
//   cmd_error       pulse on a rejected byte or a timeout
//   busy            high while an argument is being collected
// All outputs are registered; they respond one cycle after the rx_done sample.

module uart_cmd_parser #(
    parameter logic [7:0]  CMD_RUN     = 8'h72,
    parameter logic [7:0]  CMD_MODE    = 8'h6D,
    parameter logic [7:0]  CMD_CLEAR   = 8'h63,
    parameter logic [7:0]  CMD_SET     = 8'h73,
    parameter int unsigned ARG_W       = 14,
    parameter int unsigned ARG_DIGITS  = 4,
    parameter int unsigned TIMEOUT     = 1_000_000,
    parameter bit          MODE_TOGGLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic             uart_enable,
    output logic             uart_clear,
    output logic             uart_mode,
    output logic [ARG_W-1:0] arg_value,
    output logic             arg_valid,
    output logic             cmd_error,
    output logic             busy
);

    // Accumulator is wide enough for 10^ARG_DIGITS - 1.
    localparam int unsigned ACC_W = $clog2(10 ** ARG_DIGITS);
    localparam int unsigned CNT_W = $clog2(ARG_DIGITS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam int unsigned CMP_W = (ACC_W > ARG_W) ? ACC_W : ARG_W;

    typedef enum logic [0:0] {StIdle, StArg} state_e;

    state_e           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [TMO_W-1:0] tmo_cnt;

    logic             is_digit;
    logic             is_eol;
    logic [ACC_W-1:0] acc_next;
    logic [ARG_W-1:0] arg_sat;

    always_comb begin
        is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        // Low nibble of an ASCII digit is its value; the product cannot overflow
        // because a digit is only accepted while count < ARG_DIGITS.
        acc_next = acc * ACC_W'(10) + ACC_W'(rx_data[3:0]);
        if (CMP_W'(acc) > CMP_W'({ARG_W{1'b1}})) begin
            arg_sat = {ARG_W{1'b1}};
        end else begin
            arg_sat = ARG_W'(acc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            acc         <= '0;
            count       <= '0;
            tmo_cnt     <= '0;
            uart_enable <= 1'b0;
            uart_clear  <= 1'b0;
            uart_mode   <= 1'b0;
            arg_value   <= '0;
            arg_valid   <= 1'b0;
            cmd_error   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            uart_enable <= 1'b0;
            uart_clear  <= 1'b0;
            arg_valid   <= 1'b0;
            cmd_error   <= 1'b0;
            if (!MODE_TOGGLE) begin
                uart_mode <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (rx_done) begin
                        if (rx_data == CMD_RUN) begin
                            uart_enable <= 1'b1;
                        end else if (rx_data == CMD_CLEAR) begin
                            uart_clear <= 1'b1;
                        end else if (rx_data == CMD_MODE) begin
                            uart_mode <= MODE_TOGGLE ? ~uart_mode : 1'b1;
                        end else if (rx_data == CMD_SET) begin
                            state   <= StArg;
                            busy    <= 1'b1;
                            acc     <= '0;
                            count   <= '0;
                            tmo_cnt <= '0;
                        end else if (!is_eol) begin
                            cmd_error <= 1'b1;
                        end
                    end
                end

                StArg: begin
                    if (rx_done) begin
                        // A byte landing on the timeout cycle takes priority.
                        tmo_cnt <= '0;
                        if (is_digit && (count < CNT_W'(ARG_DIGITS))) begin
                            acc   <= acc_next;
                            count <= count + 1'b1;
                        end else if (is_eol && (count != '0)) begin
                            arg_value <= arg_sat;
                            arg_valid <= 1'b1;
                            state     <= StIdle;
                            busy      <= 1'b0;
                        end else begin
                            // Too many digits, empty argument, or a stray byte.
                            cmd_error <= 1'b1;
                            state     <= StIdle;
                            busy      <= 1'b0;
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        cmd_error <= 1'b1;
                        state     <= StIdle;
                        busy      <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: two instances (default widths with toggling
// mode, and ARG_W=10 with pulsed mode) share one byte stream and are compared
// every cycle against a byte-level behavioural model, plus literal checks.

module tb_uart_cmd_parser;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;

    always #5 clk = ~clk;

    logic        en0, clr0, mode0, valid0, err0, busy0;
    logic [13:0] argv0;
    logic        en1, clr1, mode1, valid1, err1, busy1;
    logic [9:0]  argv1;

    uart_cmd_parser #(.TIMEOUT(TMO)) dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .uart_enable(en0), .uart_clear(clr0), .uart_mode(mode0),
        .arg_value(argv0), .arg_valid(valid0), .cmd_error(err0), .busy(busy0)
    );

    uart_cmd_parser #(.ARG_W(10), .MODE_TOGGLE(1'b0), .TIMEOUT(TMO)) dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .uart_enable(en1), .uart_clear(clr1), .uart_mode(mode1),
        .arg_value(argv1), .arg_valid(valid1), .cmd_error(err1), .busy(busy1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_argw[2] = '{14, 10};
    bit m_tog[2]  = '{1'b1, 1'b0};
    bit m_in_arg[2];
    int m_cnt[2];
    int m_val[2];
    int m_idle[2];
    int e_argv[2];
    bit e_en[2], e_clr[2], e_mode[2], e_valid[2], e_err[2], e_busy[2];
    bit model_live = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            for (int p = 0; p < 2; p++) begin
                int lim;
                lim = (1 << m_argw[p]) - 1;
                e_en[p] = 0; e_clr[p] = 0; e_valid[p] = 0; e_err[p] = 0;
                if (!m_tog[p]) e_mode[p] = 0;
                if (rst) begin
                    m_in_arg[p] = 0; m_cnt[p] = 0; m_val[p] = 0; m_idle[p] = 0;
                    e_mode[p] = 0; e_argv[p] = 0;
                end else if (!m_in_arg[p]) begin
                    if (rx_done) begin
                        if (rx_data == 8'h72) e_en[p] = 1;
                        else if (rx_data == 8'h63) e_clr[p] = 1;
                        else if (rx_data == 8'h6D) e_mode[p] = m_tog[p] ? !e_mode[p] : 1'b1;
                        else if (rx_data == 8'h73) begin
                            m_in_arg[p] = 1; m_cnt[p] = 0; m_val[p] = 0; m_idle[p] = 0;
                        end else if (rx_data != 8'h0D && rx_data != 8'h0A) e_err[p] = 1;
                    end
                end else if (rx_done) begin
                    m_idle[p] = 0;
                    if (rx_data >= 8'h30 && rx_data <= 8'h39 && m_cnt[p] < 4) begin
                        m_val[p] = m_val[p] * 10 + int'(rx_data) - 48;
                        m_cnt[p]++;
                    end else if ((rx_data == 8'h0D || rx_data == 8'h0A) && m_cnt[p] > 0) begin
                        e_argv[p]   = (m_val[p] > lim) ? lim : m_val[p];
                        e_valid[p]  = 1;
                        m_in_arg[p] = 0;
                    end else begin
                        e_err[p] = 1; m_in_arg[p] = 0;
                    end
                end else begin
                    m_idle[p]++;
                    if (m_idle[p] == TMO) begin
                        e_err[p] = 1; m_in_arg[p] = 0;
                    end
                end
                e_busy[p] = m_in_arg[p];
            end
            if (rst) model_live = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("en0",    32'(en0),    32'(e_en[0]));
                check("clr0",   32'(clr0),   32'(e_clr[0]));
                check("mode0",  32'(mode0),  32'(e_mode[0]));
                check("argv0",  32'(argv0),  32'(e_argv[0]));
                check("valid0", 32'(valid0), 32'(e_valid[0]));
                check("err0",   32'(err0),   32'(e_err[0]));
                check("busy0",  32'(busy0),  32'(e_busy[0]));
                check("en1",    32'(en1),    32'(e_en[1]));
                check("clr1",   32'(clr1),   32'(e_clr[1]));
                check("mode1",  32'(mode1),  32'(e_mode[1]));
                check("argv1",  32'(argv1),  32'(e_argv[1]));
                check("valid1", 32'(valid1), 32'(e_valid[1]));
                check("err1",   32'(err1),   32'(e_err[1]));
                check("busy1",  32'(busy1),  32'(e_busy[1]));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Returns on the negedge after the byte's clock edge: outputs show its effect.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 15);
        if (r < 8) return 8'h30 + 8'($urandom_range(0, 9));
        case (r)
            8: return 8'h0D;
            9: return 8'h0A;
            10: return 8'h72;
            11: return 8'h63;
            12: return 8'h6D;
            13, 14: return 8'h73;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_argv0", 32'(argv0), 32'd0);
        check("reset_busy0", 32'(busy0), 32'd0);
        check("reset_mode0", 32'(mode0), 32'd0);
        rst = 1'b0;

        // 'r' then 'c', five cycles apart
        send(8'h72);
        check("run_en0", 32'(en0), 32'd1);
        repeat (3) @(negedge clk);
        send(8'h63);
        check("clear_clr0", 32'(clr0), 32'd1);
        check("clear_en0", 32'(en0), 32'd0);

        // mode: toggling on dut0, pulses on dut1
        send(8'h6D);
        check("m1_mode0", 32'(mode0), 32'd1);
        check("m1_mode1", 32'(mode1), 32'd1);
        send(8'h6D);
        check("m2_mode0", 32'(mode0), 32'd0);
        check("m2_mode1", 32'(mode1), 32'd1);
        send(8'h6D);
        check("m3_mode0", 32'(mode0), 32'd1);
        @(negedge clk);
        check("m3_mode1_drop", 32'(mode1), 32'd0);

        // "s1234\r"
        send(8'h73);
        check("s_busy0", 32'(busy0), 32'd1);
        send_str("1234");
        send(8'h0D);
        check("s1234_argv0", 32'(argv0), 32'd1234);
        check("s1234_argv1", 32'(argv1), 32'd1023);
        check("s1234_valid0", 32'(valid0), 32'd1);
        check("s1234_busy0", 32'(busy0), 32'd0);
        check("s1234_err0", 32'(err0), 32'd0);

        // saturation on the 10-bit instance
        send_str("s2000");
        send(8'h0D);
        check("s2000_argv0", 32'(argv0), 32'd2000);
        check("s2000_argv1", 32'(argv1), 32'd1023);

        // fifth digit rejected
        send_str("s12345");
        check("digits_err0", 32'(err0), 32'd1);
        check("digits_busy0", 32'(busy0), 32'd0);
        check("digits_argv0", 32'(argv0), 32'd2000);

        // timeout after TMO idle cycles
        send_str("s12");
        repeat (TMO - 1) @(negedge clk);
        check("tmo_pre_busy0", 32'(busy0), 32'd1);
        check("tmo_pre_err0", 32'(err0), 32'd0);
        @(negedge clk);
        check("tmo_err0", 32'(err0), 32'd1);
        check("tmo_busy0", 32'(busy0), 32'd0);
        check("tmo_argv0", 32'(argv0), 32'd2000);
        send(8'h72);
        check("tmo_run_en0", 32'(en0), 32'd1);

        // byte arriving on the timeout cycle wins
        send_str("s1");
        repeat (TMO - 2) @(negedge clk);
        send(8'h32);
        check("race_err0", 32'(err0), 32'd0);
        check("race_busy0", 32'(busy0), 32'd1);
        send(8'h0D);
        check("race_argv0", 32'(argv0), 32'd12);

        // reset mid-argument
        send_str("s9");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_busy0", 32'(busy0), 32'd0);
        check("rstmid_argv0", 32'(argv0), 32'd0);
        check("rstmid_mode0", 32'(mode0), 32'd0);
        check("rstmid_err0", 32'(err0), 32'd0);
        send(8'h0D);
        check("rstmid_cr_err0", 32'(err0), 32'd0);

        // randomized traffic, including back-to-back bytes, timeouts and resets
        for (int n = 0; n < 600; n++) begin
            int gap;
            gap = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge clk);
                rx_done = 1'b0;
                rst     = 1'b0;
                rx_data = 8'($urandom);
            end
            @(negedge clk);
            rx_data = pick_byte();
            rx_done = 1'b1;
            rst     = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        rx_done = 1'b0;
        rst     = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter CMD_RUN, default 8'h72 ('r'): byte that pulses uart_enable.
REQ-002 Parameter CMD_MODE, default 8'h6D ('m'): byte that drives uart_mode.
REQ-003 Parameter CMD_CLEAR, default 8'h63 ('c'): byte that pulses uart_clear.
REQ-004 Parameter CMD_SET, default 8'h73 ('s'): byte that opens a numeric-argument command.
REQ-005 Parameter ARG_W, default 14: arg_value width in bits.
REQ-006 Parameter ARG_DIGITS, default 4: maximum decimal digits per argument, range 1..9.
REQ-007 Parameter TIMEOUT, default 1_000_000: idle cycles that abort a partial argument, minimum 2.
REQ-008 Parameter MODE_TOGGLE, default 1: 1 makes uart_mode a toggling level, 0 makes it a one-cycle pulse.
REQ-009 The block SHALL use one clock and a synchronous, active-high reset.
REQ-010 clk  input  1  clock; all state changes on the rising edge.
REQ-011 rst  input  1  synchronous, active-high reset.
REQ-012 rx_data  input  8  received byte; valid only when rx_done=1.
REQ-013 rx_done  input  1  one-cycle strobe marking a received byte.
REQ-014 uart_enable  output  1  one-cycle pulse on CMD_RUN.
REQ-015 uart_clear  output  1  one-cycle pulse on CMD_CLEAR.
REQ-016 uart_mode  output  1  level or pulse on CMD_MODE, per MODE_TOGGLE.
REQ-017 arg_value  output  ARG_W  last accepted argument; held between commands.
REQ-018 arg_valid  output  1  one-cycle pulse when arg_value updates.
REQ-019 cmd_error  output  1  one-cycle pulse on a rejected byte or a timeout.
REQ-020 busy  output  1  high while the parser is in state ARG.

Function
REQ-021 All outputs SHALL be registered, asserting in the cycle after the rx_done sample (latency 1); no output is combinational from any input.
REQ-022 FSM states SHALL be IDLE and ARG only; bytes are processed only in cycles with rx_done=1.
REQ-023 IDLE, byte = CMD_RUN, CMD_CLEAR or CMD_MODE: issue the corresponding output action and remain in IDLE.
REQ-024 IDLE, byte = CMD_SET: go to ARG; clear the accumulator, the digit count and the timeout counter.
REQ-025 IDLE, byte = 0x0D or 0x0A: ignore it and produce no output.
REQ-026 IDLE, any other byte: pulse cmd_error and remain in IDLE.
REQ-027 With MODE_TOGGLE=1, each CMD_MODE SHALL invert uart_mode, which holds between commands.
REQ-028 With MODE_TOGGLE=0, CMD_MODE SHALL pulse uart_mode for one cycle.
REQ-029 ARG, digit 0x30-0x39 with count<ARG_DIGITS: set acc = acc*10 + digit and increment count.
REQ-030 acc SHALL be computed at a width wide enough for 10^ARG_DIGITS-1.
REQ-031 ARG, digit with count==ARG_DIGITS: pulse cmd_error, go to IDLE, leave arg_value unchanged.
REQ-032 ARG, 0x0D or 0x0A with count>=1: load arg_value with min(acc, 2^ARG_W-1), pulse arg_valid, go to IDLE.
REQ-033 ARG, 0x0D or 0x0A with count==0: pulse cmd_error and go to IDLE.
REQ-034 ARG, any other byte, including command letters: pulse cmd_error and go to IDLE; the byte is not re-decoded.
REQ-035 In ARG, the timeout counter SHALL clear on every rx_done and increment on every other cycle.
REQ-036 When the timeout counter reaches TIMEOUT-1 without rx_done: go to IDLE, pulse cmd_error, leave arg_value unchanged.
REQ-037 If rx_done coincides with the timeout cycle, the byte SHALL win and the timeout is discarded.
REQ-038 At most one of uart_enable, uart_clear, arg_valid and cmd_error SHALL be high in any cycle.
REQ-039 busy SHALL equal (state==ARG), registered.

Reset
REQ-040 While rst=1 at a clock edge: state=IDLE; acc, count and timeout counter = 0; every output = 0, including arg_value and uart_mode.
REQ-041 Reset SHALL override rx_done in the same cycle.
REQ-042 Reset in the middle of an argument SHALL discard the partial argument and produce no cmd_error.

Verification
REQ-043 Bytes 'r' then 'c', 5 cycles apart -> uart_enable high exactly 1 cycle, then uart_clear high exactly 1 cycle, each 1 cycle after its rx_done.
REQ-044 MODE_TOGGLE=1, bytes 'm','m','m' -> uart_mode 0->1->0->1; with MODE_TOGGLE=0 -> three one-cycle pulses.
REQ-045 Bytes "s1234\r" -> busy high from the cycle after 's' until the cycle after CR; arg_value=1234; arg_valid one cycle; no cmd_error.
REQ-046 ARG_W=10, bytes "s2000\r" -> arg_value=1023 (saturated); "s12345" -> cmd_error on '5', state IDLE, arg_value unchanged.
REQ-047 Bytes "s12", then TIMEOUT idle cycles -> cmd_error one cycle, busy low, arg_value unchanged; a following 'r' -> uart_enable pulse.
REQ-048 Bytes "s9" then rst=1 for 1 cycle -> all outputs 0, busy 0; a following "\r" is ignored with no cmd_error.
